// File: rtl/aes_spi_pkg.sv
// aes_spi_pkg: FSM encoding and frame/counter sizing shared by the AES SPI front end.
package aes_spi_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SHIFT_IN  = 3'd1,
        START     = 3'd2,
        WAIT_CORE = 3'd3,
        SHIFT_OUT = 3'd4
    } state_t;

    localparam int FRAME_BITS = 256;

    // Counters must be able to hold the terminal value itself, hence +1.
    function automatic int cnt_width(input int max_count);
        return $clog2(max_count + 1);
    endfunction

    localparam int IN_CNT_W  = cnt_width(FRAME_BITS);
    localparam int OUT_CNT_W = cnt_width(FRAME_BITS / 2);

endpackage

// File: rtl/aes_spi_sync.sv
// aes_spi_sync: multi-flop synchroniser for an asynchronous input with single-clk rise/fall pulses.
module aes_spi_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_r;
    logic              edge_r;

    // synchroniser chain plus one trailing flop for edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_r <= {STAGES{1'b0}};
            edge_r <= 1'b0;
        end else begin
            sync_r <= {sync_r[STAGES-2:0], d};
            edge_r <= sync_r[STAGES-1];
        end
    end

    assign q    = sync_r[STAGES-1];
    assign rise = sync_r[STAGES-1] & ~edge_r;
    assign fall = ~sync_r[STAGES-1] & edge_r;

endmodule

// File: rtl/aes_spi_frontend.sv
// aes_spi_frontend: SPI slave that loads plaintext+key, starts the AES core and shifts the result out.
// Define AES_SPI_FRONTEND_DEBUG_EN to expose debug_state and the sticky frame_err flag.
module aes_spi_frontend
    import aes_spi_pkg::*;
#(
    parameter int DATA_W      = 128,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              sck,
    input  logic              sdi,
    input  logic              load,
    output logic              sdo,
    output logic              done,
    output logic [DATA_W-1:0] plaintext,
    output logic [DATA_W-1:0] key,
    output logic              start,
    input  logic              core_done,
    input  logic [DATA_W-1:0] cyphertext
`ifdef AES_SPI_FRONTEND_DEBUG_EN
    ,
    output logic [3:0]        debug_state,
    output logic              frame_err
`endif
);

    localparam int FRAME_W = 2 * DATA_W;
    localparam int CNT_W   = cnt_width(FRAME_W);
    localparam int OCNT_W  = cnt_width(DATA_W);
    localparam logic [CNT_W-1:0]  FRAME_CNT = CNT_W'(FRAME_W);
    localparam logic [OCNT_W-1:0] LAST_OUT  = OCNT_W'(DATA_W - 1);

    logic sck_rise_s, sck_fall_s, load_rise_s, load_fall_s, sdi_s;
    logic unused_sck_s, unused_load_s, unused_sdi_rise_s, unused_sdi_fall_s;

    aes_spi_sync #(.STAGES(SYNC_STAGES)) u_sync_sck (
        .clk(clk), .reset_n(reset_n), .d(sck),
        .q(unused_sck_s), .rise(sck_rise_s), .fall(sck_fall_s)
    );

    aes_spi_sync #(.STAGES(SYNC_STAGES)) u_sync_load (
        .clk(clk), .reset_n(reset_n), .d(load),
        .q(unused_load_s), .rise(load_rise_s), .fall(load_fall_s)
    );

    aes_spi_sync #(.STAGES(SYNC_STAGES)) u_sync_sdi (
        .clk(clk), .reset_n(reset_n), .d(sdi),
        .q(sdi_s), .rise(unused_sdi_rise_s), .fall(unused_sdi_fall_s)
    );

    state_t              state_r;
    logic [CNT_W-1:0]    in_cnt_r;
    logic [FRAME_W-1:0]  shreg_r;
    logic [OCNT_W-1:0]   out_cnt_r;
    logic [DATA_W-1:0]   out_r;
    logic                sdo_r, done_r, start_r;
    logic [DATA_W-1:0]   plaintext_r, key_r;

    logic                shift_en_s;
    logic [CNT_W-1:0]    in_cnt_nxt_s;

    // inbound shift qualifier; the frame-length check uses the post-shift count
    always_comb begin
        shift_en_s   = 1'b0;
        in_cnt_nxt_s = in_cnt_r;
        if ((state_r == SHIFT_IN) && sck_rise_s && (in_cnt_r != FRAME_CNT)) begin
            shift_en_s   = 1'b1;
            in_cnt_nxt_s = in_cnt_r + CNT_W'(1);
        end else begin
            shift_en_s   = 1'b0;
            in_cnt_nxt_s = in_cnt_r;
        end
    end

    // frame FSM with all datapath registers and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= IDLE;
            in_cnt_r    <= {CNT_W{1'b0}};
            shreg_r     <= {FRAME_W{1'b0}};
            out_cnt_r   <= {OCNT_W{1'b0}};
            out_r       <= {DATA_W{1'b0}};
            sdo_r       <= 1'b0;
            done_r      <= 1'b0;
            start_r     <= 1'b0;
            plaintext_r <= {DATA_W{1'b0}};
            key_r       <= {DATA_W{1'b0}};
        end else begin
            start_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (load_rise_s) begin
                        in_cnt_r <= {CNT_W{1'b0}};
                        state_r  <= SHIFT_IN;
                    end
                end
                SHIFT_IN: begin
                    if (shift_en_s) begin
                        shreg_r <= {shreg_r[FRAME_W-2:0], sdi_s};
                    end
                    in_cnt_r <= in_cnt_nxt_s;
                    if (load_fall_s) begin
                        state_r <= (in_cnt_nxt_s == FRAME_CNT) ? START : IDLE;
                    end
                end
                START: begin
                    plaintext_r <= shreg_r[FRAME_W-1:DATA_W];
                    key_r       <= shreg_r[DATA_W-1:0];
                    start_r     <= 1'b1;
                    state_r     <= WAIT_CORE;
                end
                WAIT_CORE: begin
                    if (core_done) begin
                        out_r     <= cyphertext;
                        sdo_r     <= cyphertext[DATA_W-1];
                        out_cnt_r <= {OCNT_W{1'b0}};
                        done_r    <= 1'b1;
                        state_r   <= SHIFT_OUT;
                    end
                end
                SHIFT_OUT: begin
                    if (load_rise_s) begin
                        // a new frame pre-empts the remaining read-out
                        done_r   <= 1'b0;
                        sdo_r    <= 1'b0;
                        in_cnt_r <= {CNT_W{1'b0}};
                        state_r  <= SHIFT_IN;
                    end else if (sck_fall_s) begin
                        out_r     <= {out_r[DATA_W-2:0], 1'b0};
                        sdo_r     <= out_r[DATA_W-2];
                        out_cnt_r <= out_cnt_r + OCNT_W'(1);
                        if (out_cnt_r == LAST_OUT) begin
                            done_r  <= 1'b0;
                            state_r <= IDLE;
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign sdo       = sdo_r;
    assign done      = done_r;
    assign start     = start_r;
    assign plaintext = plaintext_r;
    assign key       = key_r;

`ifdef AES_SPI_FRONTEND_DEBUG_EN
    logic frame_err_r;

    // sticky short-frame flag, cleared when a good frame is committed
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_err_r <= 1'b0;
        end else if (state_r == START) begin
            frame_err_r <= 1'b0;
        end else if ((state_r == SHIFT_IN) && load_fall_s && (in_cnt_nxt_s != FRAME_CNT)) begin
            frame_err_r <= 1'b1;
        end
    end

    assign debug_state = {1'b0, state_r};
    assign frame_err   = frame_err_r;
`endif

endmodule

// File: tb/tb_aes_spi_frontend.sv
// tb_aes_spi_frontend: randomized self-checking bench with a frame-level reference model.
module tb_aes_spi_frontend;

    localparam int DATA_W = 128;
    localparam int HALF   = 4;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              sck = 1'b0;
    logic              sdi = 1'b0;
    logic              load = 1'b0;
    logic              core_done = 1'b0;
    logic [DATA_W-1:0] cyphertext = {DATA_W{1'b0}};
    logic              sdo, done, start;
    logic [DATA_W-1:0] plaintext, key;
`ifdef AES_SPI_FRONTEND_DEBUG_EN
    logic [3:0]        debug_state;
    logic              frame_err;
    logic              exp_ferr = 1'b0;
`endif

    int tests_run = 0;
    int tests_failed = 0;
    int start_cnt = 0;
    int exp_starts = 0;
    logic [DATA_W-1:0] exp_pt = {DATA_W{1'b0}};
    logic [DATA_W-1:0] exp_key = {DATA_W{1'b0}};

    aes_spi_frontend #(.DATA_W(DATA_W), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset_n(reset_n), .sck(sck), .sdi(sdi), .load(load),
        .sdo(sdo), .done(done), .plaintext(plaintext), .key(key), .start(start),
        .core_done(core_done), .cyphertext(cyphertext)
`ifdef AES_SPI_FRONTEND_DEBUG_EN
        , .debug_state(debug_state), .frame_err(frame_err)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (start) start_cnt <= start_cnt + 1;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    task automatic send_frame(input logic [255:0] data, input int nbits);
        load = 1'b1;
        wait_clk(HALF);
        for (int i = 0; i < nbits; i++) begin
            sdi = (i < 256) ? data[255-i] : 1'($urandom_range(0, 1));
            wait_clk(HALF);
            sck = 1'b1;
            wait_clk(HALF);
            sck = 1'b0;
        end
        wait_clk(HALF);
        load = 1'b0;
        wait_clk(8);
    endtask

    // Reference model: only a frame of at least 256 bits commits its first 256 bits.
    task automatic run_frame(input string tag, input logic [255:0] data, input int nbits);
        send_frame(data, nbits);
        if (nbits >= 256) begin
            exp_pt  = data[255:128];
            exp_key = data[127:0];
            exp_starts++;
`ifdef AES_SPI_FRONTEND_DEBUG_EN
            exp_ferr = 1'b0;
`endif
        end else begin
`ifdef AES_SPI_FRONTEND_DEBUG_EN
            exp_ferr = 1'b1;
`endif
        end
        check_eq({tag, "_starts"}, 256'(start_cnt), 256'(exp_starts));
        check_eq({tag, "_pt"}, 256'(plaintext), 256'(exp_pt));
        check_eq({tag, "_key"}, 256'(key), 256'(exp_key));
`ifdef AES_SPI_FRONTEND_DEBUG_EN
        check_eq({tag, "_ferr"}, 256'(frame_err), 256'(exp_ferr));
`endif
    endtask

    task automatic core_respond(input string tag, input logic [DATA_W-1:0] ct);
        wait_clk($urandom_range(1, 6));
        check_eq({tag, "_done_pre"}, 256'(done), 256'(0));
        cyphertext = ct;
        core_done  = 1'b1;
        wait_clk(1);
        check_eq({tag, "_done"}, 256'(done), 256'(1));
        check_eq({tag, "_sdo_msb"}, 256'(sdo), 256'(ct[DATA_W-1]));
        core_done = 1'b0;
    endtask

    task automatic read_out(input int nbits, output logic [DATA_W-1:0] got);
        got = {DATA_W{1'b0}};
        for (int i = 0; i < nbits; i++) begin
            wait_clk(HALF);
            got[DATA_W-1-i] = sdo;
            sck = 1'b1;
            wait_clk(HALF);
            sck = 1'b0;
        end
        wait_clk(HALF);
    endtask

    task automatic full_result(input string tag, input logic [DATA_W-1:0] ct);
        logic [DATA_W-1:0] got;
        core_respond(tag, ct);
        read_out(DATA_W, got);
        check_eq({tag, "_readback"}, 256'(got), 256'(ct));
        check_eq({tag, "_done_post"}, 256'(done), 256'(0));
    endtask

    initial begin
        logic [255:0]      frame;
        logic [DATA_W-1:0] ct, partial;
        int                nbits;

        wait_clk(3);
        check_eq("rst_sdo", 256'(sdo), 256'(0));
        check_eq("rst_done", 256'(done), 256'(0));
        check_eq("rst_start", 256'(start), 256'(0));
        check_eq("rst_pt", 256'(plaintext), 256'(0));
        check_eq("rst_key", 256'(key), 256'(0));
        reset_n = 1'b1;
        wait_clk(4);

        // FIPS-197 A.1
        frame = {128'h3243F6A8885A308D313198A2E0370734, 128'h2B7E151628AED2A6ABF7158809CF4F3C};
        run_frame("a1", frame, 256);
        full_result("a1", 128'h3925841D02DC09FBDC118597196A0B32);

        run_frame("short200", rand256(), 200);

        run_frame("long260", rand256(), 260);
        full_result("long260", DATA_W'(rand256()));

        for (int n = 0; n < 4; n++) begin
            frame = rand256();
            nbits = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 255) : 256 + $urandom_range(0, 3);
            run_frame($sformatf("rnd%0d", n), frame, nbits);
            if (nbits >= 256) full_result($sformatf("rnd%0d", n), DATA_W'(rand256()));
        end

        // Reset in the middle of the read-out, after 60 falls.
        frame = {128'h3243F6A8885A308D313198A2E0370734, 128'h2B7E151628AED2A6ABF7158809CF4F3C};
        ct = 128'h3925841D02DC09FBDC118597196A0B32;
        run_frame("rst_mid", frame, 256);
        core_respond("rst_mid", ct);
        read_out(60, partial);
        check_eq("rst_mid_partial", 256'(partial[DATA_W-1 -: 60]), 256'(ct[DATA_W-1 -: 60]));
        check_eq("rst_mid_sdo_pre", 256'(sdo), 256'(ct[DATA_W-61]));
        reset_n = 1'b0;
        #1;
        check_eq("rst_mid_done", 256'(done), 256'(0));
        check_eq("rst_mid_sdo", 256'(sdo), 256'(0));
        check_eq("rst_mid_key", 256'(key), 256'(0));
`ifdef AES_SPI_FRONTEND_DEBUG_EN
        check_eq("rst_mid_state", 256'(debug_state), 256'(0));
        exp_ferr = 1'b0;
`endif
        exp_pt  = {DATA_W{1'b0}};
        exp_key = {DATA_W{1'b0}};
        wait_clk(3);
        reset_n = 1'b1;
        wait_clk(4);

        // FIPS-197 C.1
        frame = {128'h00112233445566778899AABBCCDDEEFF, 128'h000102030405060708090A0B0C0D0E0F};
        run_frame("c1", frame, 256);
        full_result("c1", 128'h69C4E0D86A7B0430D8CDB78070B4C55A);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
